// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM read arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic PORT_CPU   = 1'b0;
    localparam logic PORT_EMU   = 1'b1;
    localparam int   AW_DEFAULT = 19;
    localparam int   CNT_W      = 4;

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way round-robin picker: a lone requester wins; on a tie the port not served last wins.
module rom_arb_rr
    import rom_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic emu_req,
    input  logic last,
    output logic grant
);

    // Grant selection from the request pair and last-served pointer
    always_comb begin
        grant = PORT_CPU;
        if (cpu_req && emu_req) begin
            grant = (last == PORT_CPU) ? PORT_EMU : PORT_CPU;
        end else if (emu_req) begin
            grant = PORT_EMU;
        end else begin
            grant = PORT_CPU;
        end
    end

endmodule

// File: rtl/rom_arb.sv
// Shares one fixed-latency ROM between a CPU port and an emulator port, one access at a time.
module rom_arb
    import rom_arb_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    input  logic          emu_req,
    input  logic [AW-1:0] emu_addr,
    output logic          emu_ack,
    output logic [7:0]    emu_rdata,
    output logic [AW-1:0] rom_addr,
    output logic          rom_oe,
    input  logic [7:0]    rom_data
);

    if (LAT < 1 || LAT > 15) begin : g_lat_check
        $error("rom_arb: LAT must be within 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             gnt_r, gnt_nxt_s;
    logic             last_r, last_nxt_s;
    logic             pick_s;
    logic [AW-1:0]    addr_nxt_s;
    logic             oe_nxt_s;
    logic             cpu_ack_nxt_s, emu_ack_nxt_s;
    logic [7:0]       cpu_rdata_nxt_s, emu_rdata_nxt_s;

    rom_arb_rr u_rr (
        .cpu_req (cpu_req),
        .emu_req (emu_req),
        .last    (last_r),
        .grant   (pick_s)
    );

    // Next-state and next-output computation; every register holds unless its state says otherwise
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        gnt_nxt_s       = gnt_r;
        last_nxt_s      = last_r;
        addr_nxt_s      = rom_addr;
        oe_nxt_s        = rom_oe;
        cpu_ack_nxt_s   = 1'b0;
        emu_ack_nxt_s   = 1'b0;
        cpu_rdata_nxt_s = cpu_rdata;
        emu_rdata_nxt_s = emu_rdata;
        case (state_r)
            IDLE: begin
                if (cpu_req || emu_req) begin
                    gnt_nxt_s   = pick_s;
                    addr_nxt_s  = (pick_s == PORT_CPU) ? cpu_addr : emu_addr;
                    oe_nxt_s    = 1'b1;
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = WAIT;
                end else begin
                    oe_nxt_s    = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    if (gnt_r == PORT_CPU) begin
                        cpu_ack_nxt_s   = 1'b1;
                        cpu_rdata_nxt_s = rom_data;
                    end else begin
                        emu_ack_nxt_s   = 1'b1;
                        emu_rdata_nxt_s = rom_data;
                    end
                    oe_nxt_s    = 1'b0;
                    state_nxt_s = ACK;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ACK: begin
                last_nxt_s  = gnt_r;
                state_nxt_s = IDLE;
            end
            default: begin
                oe_nxt_s    = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            gnt_r     <= PORT_CPU;
            last_r    <= PORT_EMU;
            rom_addr  <= '0;
            rom_oe    <= 1'b0;
            cpu_ack   <= 1'b0;
            emu_ack   <= 1'b0;
            cpu_rdata <= 8'h00;
            emu_rdata <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            gnt_r     <= gnt_nxt_s;
            last_r    <= last_nxt_s;
            rom_addr  <= addr_nxt_s;
            rom_oe    <= oe_nxt_s;
            cpu_ack   <= cpu_ack_nxt_s;
            emu_ack   <= emu_ack_nxt_s;
            cpu_rdata <= cpu_rdata_nxt_s;
            emu_rdata <= emu_rdata_nxt_s;
        end
    end

endmodule

// File: tb/tb_rom_arb.sv
// Directed bench for rom_arb: instance 0 uses LAT=2, instance 1 LAT=1, instance 2 LAT=15.
module tb_rom_arb;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req   [3];
    logic          emu_req   [3];
    logic          cpu_ack   [3];
    logic          emu_ack   [3];
    logic          rom_oe    [3];
    logic [AW-1:0] cpu_addr  [3];
    logic [AW-1:0] emu_addr  [3];
    logic [AW-1:0] rom_addr  [3];
    logic [7:0]    cpu_rdata [3];
    logic [7:0]    emu_rdata [3];
    logic [7:0]    rom_data  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // ROM image: two marked bytes, everything else a fold of the address
    function automatic logic [7:0] img(input logic [AW-1:0] a);
        if (a == 19'h12345) return 8'hA5;
        else if (a == 19'h7FFFF) return 8'h5A;
        else return a[7:0] ^ a[15:8] ^ {5'b00000, a[18:16]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LG = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        int            stable_r = 0;
        logic [AW-1:0] prev_r   = '0;

        // ROM model: data is garbage until the address has been stable LAT-1 cycles
        always @(negedge clk) begin
            if (rom_addr[g] != prev_r) stable_r <= 0;
            else if (stable_r < 100) stable_r <= stable_r + 1;
            prev_r <= rom_addr[g];
        end
        assign rom_data[g] = (stable_r >= LG - 1) ? img(rom_addr[g]) : 8'hEE;

        rom_arb #(.LAT(LG), .AW(AW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cpu_req   (cpu_req[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .emu_req   (emu_req[g]),
            .emu_addr  (emu_addr[g]),
            .emu_ack   (emu_ack[g]),
            .emu_rdata (emu_rdata[g]),
            .rom_addr  (rom_addr[g]),
            .rom_oe    (rom_oe[g]),
            .rom_data  (rom_data[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Count falling edges until either ack of instance idx is seen, bounded by budget
    task automatic wait_ack(input int idx, input int budget, input string tag,
                            output int k, output logic got_emu);
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            k++;
            if (cpu_ack[idx] || emu_ack[idx]) break;
        end
        if (!(cpu_ack[idx] || emu_ack[idx]))
            chk({tag, "_timeout"}, 32'(cpu_ack[idx] | emu_ack[idx]), 32'd1);
        else
            chk({tag, "_oneack"}, 32'(cpu_ack[idx] & emu_ack[idx]), 32'd0);
        got_emu = emu_ack[idx];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        logic e;
        logic seen;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_req[i]  = 1'b0;
            emu_req[i]  = 1'b0;
            cpu_addr[i] = '0;
            emu_addr[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_oe",     32'(rom_oe[0]),    32'd0);
        chk("rst_addr",   32'(rom_addr[0]),  32'd0);
        chk("rst_cack",   32'(cpu_ack[0]),   32'd0);
        chk("rst_eack",   32'(emu_ack[0]),   32'd0);
        chk("rst_cdata",  32'(cpu_rdata[0]), 32'd0);
        chk("rst_edata",  32'(emu_rdata[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie right after reset: CPU first, EMU LAT+2 clocks later
        cpu_req[0] = 1'b1; cpu_addr[0] = 19'h00100;
        emu_req[0] = 1'b1; emu_addr[0] = 19'h20304;
        wait_ack(0, 10, "t032a", k, e);
        chk("t032a_lat",   32'(k), 32'd3);
        chk("t032a_port",  32'(e), 32'd0);
        chk("t032a_data",  32'(cpu_rdata[0]), 32'h01);
        cpu_req[0] = 1'b0;
        wait_ack(0, 10, "t032b", k, e);
        chk("t032b_gap",   32'(k), 32'd4);
        chk("t032b_port",  32'(e), 32'd1);
        chk("t032b_data",  32'(emu_rdata[0]), 32'h05);
        chk("t032b_chold", 32'(cpu_rdata[0]), 32'h01);

        // Both held: strict alternation, one access every LAT+2 clocks
        cpu_req[0] = 1'b1;
        emu_req[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_ack(0, 12, "t033", k, e);
            chk("t033_gap",  32'(k), 32'd4);
            chk("t033_port", 32'(e), 32'(i % 2));
            if (e) chk("t033_edata", 32'(emu_rdata[0]), 32'h05);
            else   chk("t033_cdata", 32'(cpu_rdata[0]), 32'h01);
        end
        cpu_req[0] = 1'b0;
        emu_req[0] = 1'b0;
        @(negedge clk);

        // CPU-only read of the marked byte, cycle by cycle
        cpu_req[0] = 1'b1; cpu_addr[0] = 19'h12345;
        @(negedge clk);
        chk("t031_addr",  32'(rom_addr[0]), 32'h12345);
        chk("t031_oe",    32'(rom_oe[0]),   32'd1);
        chk("t031_ack0",  32'(cpu_ack[0]),  32'd0);
        @(negedge clk);
        chk("t031_ack1",  32'(cpu_ack[0]),  32'd0);
        @(negedge clk);
        chk("t031_ack",   32'(cpu_ack[0]),  32'd1);
        chk("t031_data",  32'(cpu_rdata[0]), 32'hA5);
        chk("t031_oeoff", 32'(rom_oe[0]),   32'd0);
        chk("t031_eack",  32'(emu_ack[0]),  32'd0);
        cpu_req[0] = 1'b0;
        @(negedge clk);
        chk("t031_pulse", 32'(cpu_ack[0]),  32'd0);
        chk("t031_hold",  32'(cpu_rdata[0]), 32'hA5);

        // Address change after grant is ignored
        cpu_req[0] = 1'b1; cpu_addr[0] = 19'h00010;
        @(negedge clk);
        chk("t034_addr",  32'(rom_addr[0]), 32'h00010);
        cpu_addr[0] = 19'h7FFFF;
        @(negedge clk);
        chk("t034_stay",  32'(rom_addr[0]), 32'h00010);
        @(negedge clk);
        chk("t034_ack",   32'(cpu_ack[0]),  32'd1);
        chk("t034_data",  32'(cpu_rdata[0]), 32'h10);
        cpu_req[0] = 1'b0;
        @(negedge clk);

        // Reset in WAIT: immediate clear, no ack, then a normal tie
        cpu_req[0] = 1'b1; cpu_addr[0] = 19'h7FFFF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t035_oe",    32'(rom_oe[0]),    32'd0);
        chk("t035_addr",  32'(rom_addr[0]),  32'd0);
        chk("t035_cdata", 32'(cpu_rdata[0]), 32'd0);
        chk("t035_edata", 32'(emu_rdata[0]), 32'd0);
        cpu_req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | cpu_ack[0] | emu_ack[0];
        end
        chk("t035_noack", 32'(seen), 32'd0);
        cpu_req[0] = 1'b1; cpu_addr[0] = 19'h20304;
        emu_req[0] = 1'b1; emu_addr[0] = 19'h00100;
        wait_ack(0, 10, "t035a", k, e);
        chk("t035a_lat",  32'(k), 32'd3);
        chk("t035a_port", 32'(e), 32'd0);
        chk("t035a_data", 32'(cpu_rdata[0]), 32'h05);
        cpu_req[0] = 1'b0;
        wait_ack(0, 10, "t035b", k, e);
        chk("t035b_gap",  32'(k), 32'd4);
        chk("t035b_port", 32'(e), 32'd1);
        chk("t035b_data", 32'(emu_rdata[0]), 32'h01);
        emu_req[0] = 1'b0;
        @(negedge clk);

        // Latency extremes and the top image address
        cpu_req[1] = 1'b1; cpu_addr[1] = 19'h7FFFF;
        wait_ack(1, 10, "t036a", k, e);
        chk("t036a_lat",  32'(k), 32'd2);
        chk("t036a_port", 32'(e), 32'd0);
        chk("t036a_data", 32'(cpu_rdata[1]), 32'h5A);
        cpu_req[1] = 1'b0;
        emu_req[2] = 1'b1; emu_addr[2] = 19'h12345;
        wait_ack(2, 30, "t036b", k, e);
        chk("t036b_lat",  32'(k), 32'd16);
        chk("t036b_port", 32'(e), 32'd1);
        chk("t036b_data", 32'(emu_rdata[2]), 32'hA5);
        emu_req[2] = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_arb.md
ROM_ARB -- requirements
Module: rom_arb

Interface
REQ-001 Parameter LAT, default 2, ROM read latency in clocks from address launch to data sample; legal range 1..15.
REQ-002 Parameter AW, default 19, ROM byte-address width (512 KB image).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU-port read request, level, held until cpu_ack.
REQ-006 cpu_addr  input  AW  CPU-port byte address, valid while cpu_req=1.
REQ-007 cpu_ack  output  1  one-clock strobe; cpu_rdata valid in that cycle.
REQ-008 cpu_rdata  output  8  CPU-port read data.
REQ-009 emu_req  input  1  emulator-port read request, same rules as cpu_req.
REQ-010 emu_addr  input  AW  emulator-port byte address.
REQ-011 emu_ack  output  1  emulator-port one-clock done strobe.
REQ-012 emu_rdata  output  8  emulator-port read data.
REQ-013 rom_addr  output  AW  address to shared ROM.
REQ-014 rom_oe  output  1  ROM read enable, high for the whole access.
REQ-015 rom_data  input  8  ROM read data, valid LAT clocks after rom_addr changes.

Function
REQ-016 FSM states IDLE, WAIT, ACK; exactly one access outstanding at any time.
REQ-017 IDLE: if any req=1 at edge G, grant one port, latch its address into rom_addr, set rom_oe=1, load counter with LAT-1, go WAIT; else stay IDLE with rom_oe=0.
REQ-018 Arbitration round-robin: single requester wins; both requesting -> port not served last wins; last-served pointer resets to EMU so CPU wins first tie.
REQ-019 WAIT: decrement counter each edge; at the edge where counter=0 (edge G+LAT) register rom_data into granted port's rdata, pulse its ack, drop rom_oe, go ACK.
REQ-020 ACK: ack high exactly this one cycle; next edge -> IDLE unconditionally; pointer updated to granted port.
REQ-021 Grant-to-ack latency fixed: ack high in the cycle after edge G+LAT; back-to-back accesses repeat every LAT+2 clocks.
REQ-022 req sampled only in IDLE; requester deasserts req on the edge it sees ack, so IDLE never re-grants a completed request.
REQ-023 Address/req changes after grant ignored until next IDLE; req dropped during WAIT does not abort; ack still issued.
REQ-024 rdata of each port holds last value until that port's next ack; non-granted port's ack stays 0.
REQ-025 rom_addr holds last latched value in IDLE/ACK; never changes during WAIT.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE, rom_oe=0, rom_addr=0, both acks 0, both rdata 0x00, counter 0, pointer=EMU.
REQ-027 Reset during WAIT/ACK abandons the access; no ack issued after release; first post-reset grant follows REQ-017 and REQ-018.

Structure
REQ-028 Package rom_arb_pkg holds state enum (IDLE, WAIT, ACK), port index constants (PORT_CPU=0, PORT_EMU=1), default AW=19.
REQ-029 One sub-module rom_arb_rr: 2-way round-robin picker (two reqs, last pointer in, grant index out), combinational.
REQ-030 Counter width 4 bits; LAT outside 1..15 is an elaboration error.

Verification
REQ-031 LAT=2, CPU only, cpu_addr=0x12345, ROM image byte 0xA5 there -> rom_addr=0x12345 from G+1, cpu_ack in cycle after G+2, cpu_rdata=0xA5.
REQ-032 Both req asserted together after reset -> CPU served first, emu served next with emu_ack exactly LAT+2 clocks after cpu_ack.
REQ-033 Both held continuously for 6 accesses -> strict alternation CPU,EMU,CPU,EMU,CPU,EMU; no double ack.
REQ-034 cpu_addr changed 0x00010->0x7FFFF one clock after grant -> data returned is byte at 0x00010.
REQ-035 rst_n pulsed low during WAIT -> outputs zero immediately; no ack for aborted access; next request completes normally.
REQ-036 LAT=1 and LAT=15 builds -> ack in cycle after G+1 and G+15 respectively; top address 0x7FFFF returns last image byte.
